// File: rtl/mem_access_unit.sv
// mem_access_unit: single-access controller between the address register and
// the single-port pixel RAM. Runs one read or write per request, captures read
// data into the MDR and reports completion with a one-cycle done pulse.
// All state is updated on the falling clock edge to line up with the datapath.

module mem_access_unit #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 262144,
    parameter int RD_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mdr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR      = 2'd2
    } state_t;

    // One extra bit so that MEM_DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_LIM = MEM_DEPTH[ADDR_W:0];
    localparam logic [2:0]      RD_LAT_C  = RD_LAT[2:0];

    state_t              state_r, state_s;
    logic [2:0]          cnt_r, cnt_s;
    logic                busy_s, done_s, err_s, mem_en_s, mem_we_s;
    logic [ADDR_W-1:0]   mdr_s, mem_addr_s;
    logic [DATA_W-1:0]   mem_din_s;
    logic                addr_bad_s;
    logic                wdata_unused_s;

    // Only the low DATA_W bits of the bus are stored; the rest are dropped.
    assign wdata_unused_s = ^wdata[ADDR_W-1:DATA_W];
    assign addr_bad_s     = ({1'b0, addr} >= DEPTH_LIM);

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        busy_s     = busy;
        done_s     = 1'b0;
        err_s      = 1'b0;
        mdr_s      = mdr;
        mem_en_s   = 1'b0;
        mem_we_s   = 1'b0;
        mem_addr_s = mem_addr;
        mem_din_s  = mem_din;
        case (state_r)
            ST_IDLE: begin
                if (req_rd && req_wr) begin
                    done_s = 1'b1;
                    err_s  = 1'b1;
                end else if ((req_rd || req_wr) && addr_bad_s) begin
                    done_s = 1'b1;
                    err_s  = 1'b1;
                end else if (req_rd) begin
                    mem_addr_s = addr;
                    mem_en_s   = 1'b1;
                    busy_s     = 1'b1;
                    cnt_s      = RD_LAT_C;
                    state_s    = ST_RD_WAIT;
                end else if (req_wr) begin
                    mem_addr_s = addr;
                    mem_din_s  = wdata[DATA_W-1:0];
                    mem_en_s   = 1'b1;
                    mem_we_s   = 1'b1;
                    busy_s     = 1'b1;
                    state_s    = ST_WR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // Counter reaches zero one edge before the capture edge.
                if (cnt_r == 3'd0) begin
                    mdr_s   = {{(ADDR_W-DATA_W){1'b0}}, mem_dout};
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            ST_WR: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                cnt_s   = 3'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers; synchronous reset aborts any access.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mdr      <= {ADDR_W{1'b0}};
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= {ADDR_W{1'b0}};
            mem_din  <= {DATA_W{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            busy     <= busy_s;
            done     <= done_s;
            err      <= err_s;
            mdr      <= mdr_s;
            mem_en   <= mem_en_s;
            mem_we   <= mem_we_s;
            mem_addr <= mem_addr_s;
            mem_din  <= mem_din_s;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random transactions against a
// transaction-level reference (memory image, expected latency/err/mdr).

module tb_mem_access_unit;

    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 65536;
    localparam int RD_LAT    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_rd = 1'b0, req_wr = 1'b0;
    logic [ADDR_W-1:0] addr = '0, wdata = '0;
    logic              busy, done, err, mem_en, mem_we;
    logic [ADDR_W-1:0] mdr, mem_addr;
    logic [DATA_W-1:0] mem_din, mem_dout;

    int checks = 0;
    int errors = 0;

    // RAM device model
    logic [7:0] ram [0:65535];
    logic [7:0] rd_pipe [0:RD_LAT-1];
    bit         ram_ready = 1'b0;

    // Reference model state
    logic [7:0]        ref_mem [0:65535];
    logic [ADDR_W-1:0] mdr_exp = '0;

    function automatic logic [7:0] init_byte(input int a);
        logic [31:0] v;
        v = a * 7 + 3;
        return (a == 256) ? 8'hA5 : v[7:0];
    endfunction

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .mdr(mdr), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    assign mem_dout = rd_pipe[RD_LAT-1];

    // Falling-edge RAM with RD_LAT-deep read pipeline
    always @(negedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else if (mem_en && mem_we) begin
            ram[mem_addr[15:0]] <= mem_din;
        end
        if (mem_en && !mem_we) rd_pipe[0] <= ram[mem_addr[15:0]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One transaction: predict from the reference, drive, observe, compare.
    task automatic txn(input string tag, input bit rd, input bit wr,
                       input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] d,
                       input bit keep, input bit poke);
        int exp_edges, exp_en, exp_we, n, en_cnt, we_cnt;
        bit exp_err, exp_busy, bad, got, err_seen, busy1;
        bad = (rd && wr) || ((rd || wr) && (int'(a) >= MEM_DEPTH));
        exp_err = bad;
        if (bad) begin
            exp_edges = 1; exp_en = 0; exp_we = 0; exp_busy = 0;
        end else if (rd) begin
            exp_edges = RD_LAT + 2; exp_en = 1; exp_we = 0; exp_busy = 1;
            mdr_exp = {10'b0, ref_mem[a[15:0]]};
        end else begin
            exp_edges = 2; exp_en = 1; exp_we = 1; exp_busy = 1;
            ref_mem[a[15:0]] = d[7:0];
        end
        req_rd = rd; req_wr = wr; addr = a; wdata = d;
        n = 0; en_cnt = 0; we_cnt = 0; got = 0; err_seen = 0; busy1 = 0;
        while (!got && n < 30) begin
            tick();
            n++;
            if (n == 1) begin
                busy1 = busy;
                addr  = 18'($urandom);
                wdata = 18'($urandom);
                if (poke) req_wr = 1'b1;
            end
            if (n == 2 && poke) req_wr = 1'b0;
            en_cnt += int'(mem_en);
            we_cnt += int'(mem_we);
            if (done) begin
                got = 1;
                err_seen = err;
            end
        end
        if (!keep) begin
            req_rd = 1'b0;
            req_wr = 1'b0;
        end
        chk({tag, " done_edges"}, n, exp_edges);
        chk({tag, " err"}, {31'b0, err_seen}, {31'b0, exp_err});
        chk({tag, " mdr"}, {14'b0, mdr}, {14'b0, mdr_exp});
        chk({tag, " mem_en_cycles"}, en_cnt, exp_en);
        chk({tag, " mem_we_cycles"}, we_cnt, exp_we);
        chk({tag, " busy_after_req"}, {31'b0, busy1}, {31'b0, exp_busy});
        if (!keep) begin
            tick();
            chk({tag, " done_err_width"}, {30'b0, done, err}, 32'd0);
            chk({tag, " busy_idle"}, {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        int dcount;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);

        // 1: reset with random inputs
        repeat (2) begin
            req_rd = 1'($urandom); req_wr = 1'($urandom);
            addr = 18'($urandom); wdata = 18'($urandom);
            tick();
        end
        chk("reset outputs",
            {20'b0, busy, done, err, mem_en, mem_we, 7'b0},
            32'd0);
        chk("reset mdr", {14'b0, mdr}, 32'd0);
        chk("reset mem_addr", {14'b0, mem_addr}, 32'd0);
        chk("reset mem_din", {24'b0, mem_din}, 32'd0);
        req_rd = 1'b0; req_wr = 1'b0; addr = '0; wdata = '0;
        rst = 1'b0;
        tick();

        // 2: read of preloaded word
        txn("read_100", 1'b1, 1'b0, 18'h00100, 18'h0, 1'b0, 1'b0);
        // 3: write then read back
        txn("write_200", 1'b0, 1'b1, 18'h00200, 18'h3FF5A, 1'b0, 1'b0);
        txn("read_200", 1'b1, 1'b0, 18'h00200, 18'h0, 1'b0, 1'b0);
        chk("read_200 value", {14'b0, mdr}, 32'h5A);
        // 4: illegal requests
        txn("both_req", 1'b1, 1'b1, 18'h00010, 18'h1, 1'b0, 1'b0);
        txn("bad_addr", 1'b1, 1'b0, 18'h3FFFF, 18'h0, 1'b0, 1'b0);
        txn("bad_addr_wr", 1'b0, 1'b1, 18'h10000, 18'h77, 1'b0, 1'b0);

        // 5: reset in the middle of a read
        req_rd = 1'b1; addr = 18'h00100;
        tick();
        tick();
        rst = 1'b1; req_rd = 1'b0;
        tick();
        rst = 1'b0;
        mdr_exp = '0;
        chk("midreset done", {31'b0, done}, 32'd0);
        chk("midreset mdr", {14'b0, mdr}, 32'd0);
        chk("midreset busy", {31'b0, busy}, 32'd0);
        dcount = 0;
        repeat (5) begin
            tick();
            dcount += int'(done);
        end
        chk("midreset no_done", dcount, 0);
        txn("read_after_reset", 1'b1, 1'b0, 18'h00100, 18'h0, 1'b0, 1'b0);

        // 6: back-to-back reads with ignored write pokes while busy
        txn("b2b_0", 1'b1, 1'b0, 18'h00000, 18'h0, 1'b1, 1'b1);
        txn("b2b_1", 1'b1, 1'b0, 18'h00001, 18'h0, 1'b1, 1'b1);
        txn("b2b_2", 1'b1, 1'b0, 18'h00002, 18'h0, 1'b0, 1'b1);

        // Random transactions over a small address window
        for (int k = 0; k < 40; k++) begin
            int kind;
            logic [ADDR_W-1:0] ra, rdat;
            kind = int'($urandom_range(0, 9));
            ra   = 18'($urandom_range(0, 15));
            rdat = 18'($urandom);
            if (kind == 0)
                txn("rnd_both", 1'b1, 1'b1, ra, rdat, 1'b0, 1'b0);
            else if (kind == 1)
                txn("rnd_bad", 1'($urandom), 1'b1, 18'($urandom_range(65536, 262143)), rdat, 1'b0, 1'b0);
            else if (kind < 5)
                txn("rnd_wr", 1'b0, 1'b1, ra, rdat, 1'b0, 1'b0);
            else
                txn("rnd_rd", 1'b1, 1'b0, ra, rdat, 1'b0, 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
